branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_pkg.sv | 18 +
 rtl/branch_decode.sv | 56 +++++
 rtl/branch_resolve.sv | 114 +++++++++++
 tb/tb_branch_resolve.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for execute-stage branch resolution: control opcodes and
// the redirect FSM state encoding.
package branch_resolve_pkg;

    localparam logic [4:0] OpJ   = 5'b00001;
    localparam logic [4:0] OpBne = 5'b00010;
    localparam logic [4:0] OpJal = 5'b00011;
    localparam logic [4:0] OpJr  = 5'b00100;
    localparam logic [4:0] OpBlt = 5'b00110;
    localparam logic [4:0] OpBex = 5'b10110;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRedirect = 2'd1,
        StSquash   = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_decode.sv
// Combinational decode of an execute-stage instruction into conditional-branch,
// taken and target information.
module branch_decode
    import branch_resolve_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [26:0] jtarget,
    input  logic [31:0] rd_value,
    input  logic        isNotEqual,
    input  logic        isLessThan,
    input  logic        rstatus_nonzero,
    output logic        is_cond,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] br_target;

    // Relative branches target the instruction after pc plus offset, wrapping freely.
    assign br_target = pc + 32'd1 + imm;

    always_comb begin
        is_cond = 1'b0;
        taken   = 1'b0;
        target  = 32'd0;
        case (opcode)
            OpBne: begin
                is_cond = 1'b1;
                taken   = isNotEqual;
                target  = br_target;
            end
            OpBlt: begin
                is_cond = 1'b1;
                taken   = isLessThan;
                target  = br_target;
            end
            OpBex: begin
                is_cond = 1'b1;
                taken   = rstatus_nonzero;
                target  = {5'b0, jtarget};
            end
            OpJ, OpJal: begin
                taken  = 1'b1;
                target = {5'b0, jtarget};
            end
            OpJr: begin
                taken  = 1'b1;
                target = rd_value;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves control transfers in execute, issues a held PC redirect to fetch,
// squashes wrong-path slots and keeps saturating branch statistics.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned SQUASH_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [4:0]       ex_opcode,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [26:0]      ex_target,
    input  logic [31:0]      ex_rd_value,
    input  logic             isNotEqual,
    input  logic             isLessThan,
    input  logic             rstatus_nonzero,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned SqW = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

    br_state_e      state;
    logic [SqW-1:0] squash_cnt;
    logic           dec_is_cond;
    logic           dec_taken;
    logic [31:0]    dec_target;

    branch_decode u_decode (
        .opcode          (ex_opcode),
        .pc              (ex_pc),
        .imm             (ex_imm),
        .jtarget         (ex_target),
        .rd_value        (ex_rd_value),
        .isNotEqual      (isNotEqual),
        .isLessThan      (isLessThan),
        .rstatus_nonzero (rstatus_nonzero),
        .is_cond         (dec_is_cond),
        .taken           (dec_taken),
        .target          (dec_target)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            squash_cnt     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            branch_count   <= '0;
            taken_count    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (ex_valid) begin
                        if (dec_is_cond && !(&branch_count)) begin
                            branch_count <= branch_count + CNT_W'(1);
                        end
                        if (dec_taken) begin
                            if (!(&taken_count)) begin
                                taken_count <= taken_count + CNT_W'(1);
                            end
                            state          <= StRedirect;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= dec_target;
                            flush_if_id    <= 1'b1;
                            flush_id_ex    <= 1'b1;
                        end
                    end
                end
                StRedirect: begin
                    if (fetch_ready) begin
                        redirect_valid <= 1'b0;
                        if (SQUASH_CYCLES == 0) begin
                            state       <= StIdle;
                            flush_if_id <= 1'b0;
                            flush_id_ex <= 1'b0;
                        end else begin
                            state      <= StSquash;
                            squash_cnt <= SqW'(SQUASH_CYCLES);
                        end
                    end
                end
                StSquash: begin
                    // Counter holds the squash cycles left including the current one.
                    if (squash_cnt <= SqW'(1)) begin
                        state       <= StIdle;
                        squash_cnt  <= '0;
                        flush_if_id <= 1'b0;
                        flush_id_ex <= 1'b0;
                    end else begin
                        squash_cnt <= squash_cnt - SqW'(1);
                    end
                end
                default: begin
                    state          <= StIdle;
                    redirect_valid <= 1'b0;
                    flush_if_id    <= 1'b0;
                    flush_id_ex    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a cycle-level reference model checked on
// every falling edge, plus literal expectations for the key scenarios.
module tb_branch_resolve;

    localparam int SQ = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_opcode = 5'd0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_imm = 32'd0;
    logic [26:0] ex_target = 27'd0;
    logic [31:0] ex_rd_value = 32'd0;
    logic        isNotEqual = 1'b0;
    logic        isLessThan = 1'b0;
    logic        rstatus_nonzero = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    branch_resolve #(
        .SQUASH_CYCLES (SQ),
        .CNT_W         (16)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_pc           (ex_pc),
        .ex_imm          (ex_imm),
        .ex_target       (ex_target),
        .ex_rd_value     (ex_rd_value),
        .isNotEqual      (isNotEqual),
        .isLessThan      (isLessThan),
        .rstatus_nonzero (rstatus_nonzero),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .branch_count    (branch_count),
        .taken_count     (taken_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: decode rules written directly from the opcode table.
    function automatic bit m_cond(input logic [4:0] op);
        return op == 5'b00010 || op == 5'b00110 || op == 5'b10110;
    endfunction

    function automatic bit m_taken(input logic [4:0] op, input bit ne, input bit lt, input bit rs);
        case (op)
            5'b00010: return ne;
            5'b00110: return lt;
            5'b10110: return rs;
            5'b00001, 5'b00011, 5'b00100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [4:0] op, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [26:0] tg,
                                             input logic [31:0] rd);
        if (op == 5'b00010 || op == 5'b00110) return pc + imm + 32'd1;
        if (op == 5'b00100) return rd;
        return {5'b0, tg};
    endfunction

    bit          m_wait = 1'b0;
    int          m_sq = 0;
    logic        exp_rv = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    logic [15:0] exp_bc = 16'd0;
    logic [15:0] exp_tc = 16'd0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_wait <= 1'b0;
            m_sq   <= 0;
            exp_rv <= 1'b0;
            exp_pc <= 32'd0;
            exp_bc <= 16'd0;
            exp_tc <= 16'd0;
        end else if (m_wait) begin
            if (fetch_ready) begin
                m_wait <= 1'b0;
                exp_rv <= 1'b0;
                m_sq   <= SQ;
            end
        end else if (m_sq != 0) begin
            m_sq <= m_sq - 1;
        end else if (ex_valid) begin
            if (m_cond(ex_opcode) && exp_bc != 16'hFFFF) exp_bc <= exp_bc + 16'd1;
            if (m_taken(ex_opcode, isNotEqual, isLessThan, rstatus_nonzero)) begin
                m_wait <= 1'b1;
                exp_rv <= 1'b1;
                exp_pc <= m_target(ex_opcode, ex_pc, ex_imm, ex_target, ex_rd_value);
                if (exp_tc != 16'hFFFF) exp_tc <= exp_tc + 16'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
            check("redirect_pc", redirect_pc, exp_pc);
            check("flush_if_id", {31'd0, flush_if_id}, {31'd0, (m_wait || m_sq != 0)});
            check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, (m_wait || m_sq != 0)});
            check("branch_count", {16'd0, branch_count}, {16'd0, exp_bc});
            check("taken_count", {16'd0, taken_count}, {16'd0, exp_tc});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int fl;
        int stable;

        #8;
        check("reset_rv", {31'd0, redirect_valid}, 32'd0);
        check("reset_pc", redirect_pc, 32'd0);
        check("reset_flush", {31'd0, flush_if_id | flush_id_ex}, 32'd0);
        check("reset_bc", {16'd0, branch_count}, 32'd0);
        #4 reset_n = 1'b1;
        tick();
        tick();

        // bne taken, fetch ready immediately
        ex_valid = 1'b1; ex_opcode = 5'b00010; ex_pc = 32'h10; ex_imm = 32'h5;
        isNotEqual = 1'b1; fetch_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        check("bne_rv", {31'd0, redirect_valid}, 32'd1);
        check("bne_pc", redirect_pc, 32'h16);
        fl = 1;
        repeat (5) begin
            @(negedge clock);
            fl += int'(flush_if_id);
        end
        check("bne_flush_cycles", fl, 32'd3);
        check("bne_bc", {16'd0, branch_count}, 32'd1);
        check("bne_tc", {16'd0, taken_count}, 32'd1);
        tick();

        // blt not taken
        ex_valid = 1'b1; ex_opcode = 5'b00110; isLessThan = 1'b0;
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        check("blt_rv", {31'd0, redirect_valid}, 32'd0);
        check("blt_flush", {31'd0, flush_if_id}, 32'd0);
        check("blt_bc", {16'd0, branch_count}, 32'd2);
        check("blt_tc", {16'd0, taken_count}, 32'd1);
        tick();

        // non-control opcode leaves everything alone
        ex_valid = 1'b1; ex_opcode = 5'b00000;
        tick();
        ex_valid = 1'b0;

        // jr with fetch stalled; a taken bne during the redirect is ignored
        fetch_ready = 1'b0; ex_valid = 1'b1; ex_opcode = 5'b00100; ex_rd_value = 32'hABCD;
        tick();
        ex_opcode = 5'b00010; ex_pc = 32'h100; isNotEqual = 1'b1;
        stable = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (redirect_valid && redirect_pc == 32'hABCD) stable++;
            if (i == 3) fetch_ready = 1'b1;
            tick();
        end
        ex_valid = 1'b0;
        check("jr_stable_cycles", stable, 32'd4);
        repeat (3) tick();
        check("jr_bc", {16'd0, branch_count}, 32'd2);
        check("jr_tc", {16'd0, taken_count}, 32'd2);

        // wrap-around target
        ex_valid = 1'b1; ex_opcode = 5'b00010; ex_pc = 32'hFFFF_FFFE; ex_imm = 32'h3;
        isNotEqual = 1'b1; fetch_ready = 1'b1;
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        check("wrap_pc", redirect_pc, 32'h2);
        repeat (4) tick();

        // bex taken and not taken
        ex_valid = 1'b1; ex_opcode = 5'b10110; ex_target = 27'h123; rstatus_nonzero = 1'b0;
        tick();
        rstatus_nonzero = 1'b1;
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        check("bex_pc", redirect_pc, 32'h123);
        check("bex_bc", {16'd0, branch_count}, 32'd5);
        repeat (4) tick();

        // saturate branch_count with not-taken blt
        ex_valid = 1'b1; ex_opcode = 5'b00110; isLessThan = 1'b0;
        repeat (65540) tick();
        check("sat_bc", {16'd0, branch_count}, 32'hFFFF);
        ex_opcode = 5'b00010; isNotEqual = 1'b1;
        tick();
        ex_valid = 1'b0;
        repeat (4) tick();
        check("sat_bc_after_bne", {16'd0, branch_count}, 32'hFFFF);

        // reset while squashing, then a fresh jump
        ex_valid = 1'b1; ex_opcode = 5'b00001; ex_target = 27'h77;
        tick();
        ex_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_mid_pc", redirect_pc, 32'd0);
        check("rst_mid_flush", {31'd0, flush_if_id | flush_id_ex}, 32'd0);
        check("rst_mid_bc", {16'd0, branch_count}, 32'd0);
        check("rst_mid_tc", {16'd0, taken_count}, 32'd0);
        reset_n = 1'b1;
        ex_valid = 1'b1; ex_opcode = 5'b00001; ex_target = 27'h40;
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        check("post_rst_rv", {31'd0, redirect_valid}, 32'd1);
        check("post_rst_pc", redirect_pc, 32'h40);
        check("post_rst_tc", {16'd0, taken_count}, 32'd1);
        repeat (5) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
